// File: rtl/memory_if_arbiter_if.sv
// memory_if_arbiter_if
//   Bundles the arbiter's channel, memory and status signals.
//   slave  : the arbiter's view (channel/memory requests in, grants/responses out)
//   master : the surrounding core/memory view
//   Channel 0 = load/store, channel 1 = instruction fetch.
interface memory_if_arbiter_if #(
  parameter int ADDR_N   = 32,
  parameter int DATA_N   = 32,
  parameter int ORDER_DN = 2
);
  logic                iREMOVE;
  // channel 0
  logic                iCH0_REQ;
  logic                oCH0_LOCK;
  logic                iCH0_RW;
  logic [ADDR_N-1:0]   iCH0_ADDR;
  logic [DATA_N-1:0]   iCH0_DATA;
  logic [3:0]          iCH0_MASK;
  logic                oCH0_VALID;
  logic [DATA_N-1:0]   oCH0_DATA;
  // channel 1
  logic                iCH1_REQ;
  logic                oCH1_LOCK;
  logic                iCH1_RW;
  logic [ADDR_N-1:0]   iCH1_ADDR;
  logic [DATA_N-1:0]   iCH1_DATA;
  logic [3:0]          iCH1_MASK;
  logic                oCH1_VALID;
  logic [DATA_N-1:0]   oCH1_DATA;
  // memory side
  logic                oMEM_REQ;
  logic                iMEM_LOCK;
  logic                oMEM_RW;
  logic [ADDR_N-1:0]   oMEM_ADDR;
  logic [DATA_N-1:0]   oMEM_DATA;
  logic [3:0]          oMEM_MASK;
  logic                iMEM_VALID;
  logic [DATA_N-1:0]   iMEM_DATA;
  // status
  logic [ORDER_DN:0]   oPENDING;
  logic                oERR_UNDERFLOW;

  modport slave (
    input  iREMOVE,
    input  iCH0_REQ, iCH0_RW, iCH0_ADDR, iCH0_DATA, iCH0_MASK,
    output oCH0_LOCK, oCH0_VALID, oCH0_DATA,
    input  iCH1_REQ, iCH1_RW, iCH1_ADDR, iCH1_DATA, iCH1_MASK,
    output oCH1_LOCK, oCH1_VALID, oCH1_DATA,
    output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_MASK,
    input  iMEM_LOCK, iMEM_VALID, iMEM_DATA,
    output oPENDING, oERR_UNDERFLOW
  );

  modport master (
    output iREMOVE,
    output iCH0_REQ, iCH0_RW, iCH0_ADDR, iCH0_DATA, iCH0_MASK,
    input  oCH0_LOCK, oCH0_VALID, oCH0_DATA,
    output iCH1_REQ, iCH1_RW, iCH1_ADDR, iCH1_DATA, iCH1_MASK,
    input  oCH1_LOCK, oCH1_VALID, oCH1_DATA,
    input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_MASK,
    output iMEM_LOCK, iMEM_VALID, iMEM_DATA,
    input  oPENDING, oERR_UNDERFLOW
  );
endinterface

// File: rtl/memory_if_arbiter.sv
// memory_if_arbiter
//   Shares one memory request port between channel 0 (load/store) and
//   channel 1 (fetch). Round-robin on contention, zero-latency selection.
//   A 1-bit-per-entry order queue records which channel owns each accepted
//   access so in-order memory responses are steered back to the issuer.
// Ports:
//   iCLOCK  - clock
//   inRESET - async active-low reset
//   bus     - memory_if_arbiter_if.slave: channel req/lock/resp, memory
//             req/lock/resp, iREMOVE flush, oPENDING count, sticky underflow

// Per-channel grant/response decode.
module memory_if_arbiter_ch #(
  parameter int ID = 0
)(
  input  logic accept,
  input  logic sel,
  input  logic mem_valid,
  input  logic q_empty,
  input  logic head,
  output logic lock,
  output logic valid
);
  assign lock  = ~(accept & (sel == 1'(ID)));
  assign valid = mem_valid & ~q_empty & (head == 1'(ID));
endmodule

module memory_if_arbiter #(
  parameter int ADDR_N      = 32,
  parameter int DATA_N      = 32,
  parameter int ORDER_DEPTH = 4,
  parameter int ORDER_DN    = 2
)(
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  memory_if_arbiter_if.slave    bus
);
  localparam int NUM_CH = 2;

  typedef struct packed {
    logic              rw;
    logic [ADDR_N-1:0] addr;
    logic [DATA_N-1:0] data;
    logic [3:0]        mask;
  } mem_req_t;

  mem_req_t [NUM_CH-1:0] ch_pl;
  logic     [NUM_CH-1:0] ch_req;
  logic     [NUM_CH-1:0] ch_lock;
  logic     [NUM_CH-1:0] ch_valid;
  mem_req_t              mem_pl;

  logic                   last_served;
  logic                   sel;
  logic                   mem_req;
  logic                   accept;
  logic                   pop;
  logic [ORDER_DEPTH-1:0] order_q;
  logic [ORDER_DN:0]      wp, rp, count;
  logic                   full, empty, head;
  logic                   err_underflow;

  assign ch_req   = {bus.iCH1_REQ, bus.iCH0_REQ};
  assign ch_pl[0] = {bus.iCH0_RW, bus.iCH0_ADDR, bus.iCH0_DATA, bus.iCH0_MASK};
  assign ch_pl[1] = {bus.iCH1_RW, bus.iCH1_ADDR, bus.iCH1_DATA, bus.iCH1_MASK};

  // Queue occupancy: extra pointer bit distinguishes full from empty.
  assign count = wp - rp;
  assign full  = count[ORDER_DN];
  assign empty = (count == '0);
  assign head  = order_q[rp[ORDER_DN-1:0]];

  // Selection: lone requester wins; on contention the one not served last.
  // last_served only moves on accept, so a locked selection stays put.
  always_comb begin
    sel = 1'b0;
    if (ch_req == 2'b11) sel = ~last_served;
    else if (ch_req[1])  sel = 1'b1;
  end

  assign mem_pl  = ch_pl[sel];
  assign mem_req = (|ch_req) & ~full & ~bus.iREMOVE;
  assign accept  = mem_req & ~bus.iMEM_LOCK;
  assign pop     = bus.iMEM_VALID & ~empty;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wp            <= '0;
      rp            <= '0;
      order_q       <= '0;
      last_served   <= 1'b1;
      err_underflow <= 1'b0;
    end else if (bus.iREMOVE) begin
      wp            <= '0;
      rp            <= '0;
      last_served   <= 1'b1;
      err_underflow <= 1'b0;
    end else begin
      if (accept) begin
        order_q[wp[ORDER_DN-1:0]] <= sel;
        wp                        <= wp + (ORDER_DN+1)'(1);
        last_served               <= sel;
      end
      if (pop)
        rp <= rp + (ORDER_DN+1)'(1);
      // Response with nothing outstanding: flushed or reset-orphaned access.
      if (bus.iMEM_VALID & empty)
        err_underflow <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    memory_if_arbiter_ch #(.ID(g)) u_ch (
      .accept    (accept),
      .sel       (sel),
      .mem_valid (bus.iMEM_VALID),
      .q_empty   (empty),
      .head      (head),
      .lock      (ch_lock[g]),
      .valid     (ch_valid[g])
    );
  end

  assign bus.oCH0_LOCK      = ch_lock[0];
  assign bus.oCH1_LOCK      = ch_lock[1];
  assign bus.oCH0_VALID     = ch_valid[0];
  assign bus.oCH1_VALID     = ch_valid[1];
  assign bus.oCH0_DATA      = bus.iMEM_DATA;
  assign bus.oCH1_DATA      = bus.iMEM_DATA;

  assign bus.oMEM_REQ       = mem_req;
  assign bus.oMEM_RW        = mem_pl.rw;
  assign bus.oMEM_ADDR      = mem_pl.addr;
  assign bus.oMEM_DATA      = mem_pl.data;
  assign bus.oMEM_MASK      = mem_pl.mask;

  assign bus.oPENDING       = count;
  assign bus.oERR_UNDERFLOW = err_underflow;
endmodule

// File: tb/tb_memory_if_arbiter.sv
// tb_memory_if_arbiter
//   Directed vectors with hand-computed expectations for memory_if_arbiter.
//   Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_memory_if_arbiter;
  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  memory_if_arbiter_if #(.ADDR_N(32), .DATA_N(32), .ORDER_DN(2)) bus();

  memory_if_arbiter #(
    .ADDR_N(32), .DATA_N(32), .ORDER_DEPTH(4), .ORDER_DN(2)
  ) dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .bus     (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  initial begin
    bus.iREMOVE    = 0;
    bus.iCH0_REQ   = 0; bus.iCH0_RW = 0; bus.iCH0_ADDR = 0; bus.iCH0_DATA = 0; bus.iCH0_MASK = 0;
    bus.iCH1_REQ   = 0; bus.iCH1_RW = 0; bus.iCH1_ADDR = 0; bus.iCH1_DATA = 0; bus.iCH1_MASK = 0;
    bus.iMEM_LOCK  = 0; bus.iMEM_VALID = 0; bus.iMEM_DATA = 0;

    // reset state
    #12;
    chk("rst_mem_req",  bus.oMEM_REQ, 0);
    chk("rst_pending",  bus.oPENDING, 0);
    chk("rst_ch0_valid", bus.oCH0_VALID, 0);
    chk("rst_ch1_valid", bus.oCH1_VALID, 0);
    chk("rst_err",      bus.oERR_UNDERFLOW, 0);
    chk("rst_ch0_lock", bus.oCH0_LOCK, 1);
    inRESET = 1;
    tick();

    // single ch0 read
    bus.iCH0_REQ = 1; bus.iCH0_RW = 0; bus.iCH0_ADDR = 32'h100; bus.iCH0_MASK = 4'hF;
    #1;
    chk("t1_mem_req",  bus.oMEM_REQ, 1);
    chk("t1_ch0_lock", bus.oCH0_LOCK, 0);
    chk("t1_ch1_lock", bus.oCH1_LOCK, 1);
    chk("t1_mem_addr", bus.oMEM_ADDR, 32'h100);
    chk("t1_mem_rw",   bus.oMEM_RW, 0);
    chk("t1_pend0",    bus.oPENDING, 0);
    tick();
    bus.iCH0_REQ = 0;
    #1;
    chk("t1_pend1", bus.oPENDING, 1);
    bus.iMEM_VALID = 1; bus.iMEM_DATA = 32'hDEADBEEF;
    #1;
    chk("t1_ch0_valid", bus.oCH0_VALID, 1);
    chk("t1_ch0_data",  bus.oCH0_DATA, 32'hDEADBEEF);
    chk("t1_ch1_valid", bus.oCH1_VALID, 0);
    tick();
    bus.iMEM_VALID = 0;
    #1;
    chk("t1_pend_end", bus.oPENDING, 0);

    // flush so last-served is back to 1: ch0 wins the first tie
    bus.iREMOVE = 1; tick(); bus.iREMOVE = 0;

    // both request continuously, 6 cycles
    bus.iCH0_REQ = 1; bus.iCH0_ADDR = 32'hA0; bus.iCH0_RW = 1; bus.iCH0_DATA = 32'h11;
    bus.iCH1_REQ = 1; bus.iCH1_ADDR = 32'hB0; bus.iCH1_RW = 0; bus.iCH1_DATA = 32'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
        chk($sformatf("t2_ch0_lock%0d", i), bus.oCH0_LOCK, (i % 2 == 0) ? 0 : 1);
        chk($sformatf("t2_ch1_lock%0d", i), bus.oCH1_LOCK, (i % 2 == 1) ? 0 : 1);
        chk($sformatf("t2_addr%0d", i), bus.oMEM_ADDR, (i % 2 == 0) ? 32'hA0 : 32'hB0);
        chk($sformatf("t2_data%0d", i), bus.oMEM_DATA, (i % 2 == 0) ? 32'h11 : 32'h22);
      end else begin
        chk($sformatf("t2_full_lock0_%0d", i), bus.oCH0_LOCK, 1);
        chk($sformatf("t2_full_lock1_%0d", i), bus.oCH1_LOCK, 1);
        chk($sformatf("t2_full_req%0d", i), bus.oMEM_REQ, 0);
        chk($sformatf("t2_full_pend%0d", i), bus.oPENDING, 4);
      end
      tick();
    end
    bus.iCH0_REQ = 0; bus.iCH1_REQ = 0;
    for (int i = 0; i < 4; i++) begin
      bus.iMEM_VALID = 1; bus.iMEM_DATA = 32'h1000 + i;
      #1;
      chk($sformatf("t2_rsp_ch0_%0d", i), bus.oCH0_VALID, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_rsp_ch1_%0d", i), bus.oCH1_VALID, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    bus.iMEM_VALID = 0;
    #1;
    chk("t2_pend_end", bus.oPENDING, 0);

    // lock hold: last served is ch1, so ch0 is selected and must stay so
    bus.iMEM_LOCK = 1; bus.iCH0_REQ = 1; bus.iCH1_REQ = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t3_addr%0d", i), bus.oMEM_ADDR, 32'hA0);
      chk($sformatf("t3_req%0d", i), bus.oMEM_REQ, 1);
      chk($sformatf("t3_lock0_%0d", i), bus.oCH0_LOCK, 1);
      chk($sformatf("t3_lock1_%0d", i), bus.oCH1_LOCK, 1);
      tick();
    end
    bus.iMEM_LOCK = 0;
    #1;
    chk("t3_rel_lock0", bus.oCH0_LOCK, 0);
    chk("t3_rel_lock1", bus.oCH1_LOCK, 1);
    tick();
    #1;
    chk("t3_next_lock0", bus.oCH0_LOCK, 1);
    chk("t3_next_lock1", bus.oCH1_LOCK, 0);
    chk("t3_next_addr",  bus.oMEM_ADDR, 32'hB0);
    tick();
    bus.iCH0_REQ = 0; bus.iCH1_REQ = 0;
    #1;
    chk("t3_pend2", bus.oPENDING, 2);
    for (int i = 0; i < 2; i++) begin
      bus.iMEM_VALID = 1;
      #1;
      chk($sformatf("t3_rsp_ch0_%0d", i), bus.oCH0_VALID, (i == 0) ? 1 : 0);
      chk($sformatf("t3_rsp_ch1_%0d", i), bus.oCH1_VALID, (i == 1) ? 1 : 0);
      tick();
    end
    bus.iMEM_VALID = 0;

    // full queue + pop + pending ch1
    bus.iCH0_REQ = 1;
    for (int i = 0; i < 4; i++) tick();
    bus.iCH0_REQ = 0;
    bus.iCH1_REQ = 1; bus.iMEM_VALID = 1;
    #1;
    chk("t4_full_pend",  bus.oPENDING, 4);
    chk("t4_full_req",   bus.oMEM_REQ, 0);
    chk("t4_full_lock1", bus.oCH1_LOCK, 1);
    chk("t4_pop_ch0",    bus.oCH0_VALID, 1);
    tick();
    bus.iMEM_VALID = 0;
    #1;
    chk("t4_req_rise", bus.oMEM_REQ, 1);
    chk("t4_lock1",    bus.oCH1_LOCK, 0);
    chk("t4_pend3",    bus.oPENDING, 3);
    tick();
    bus.iCH1_REQ = 0;
    #1;
    chk("t4_pend4", bus.oPENDING, 4);
    for (int i = 0; i < 4; i++) begin
      bus.iMEM_VALID = 1;
      #1;
      chk($sformatf("t4_rsp_ch0_%0d", i), bus.oCH0_VALID, (i < 3) ? 1 : 0);
      chk($sformatf("t4_rsp_ch1_%0d", i), bus.oCH1_VALID, (i == 3) ? 1 : 0);
      tick();
    end
    bus.iMEM_VALID = 0;

    // underflow
    bus.iMEM_VALID = 1;
    #1;
    chk("t5_ch0_valid", bus.oCH0_VALID, 0);
    chk("t5_ch1_valid", bus.oCH1_VALID, 0);
    chk("t5_err_pre",   bus.oERR_UNDERFLOW, 0);
    tick();
    bus.iMEM_VALID = 0;
    #1;
    chk("t5_err_set",  bus.oERR_UNDERFLOW, 1);
    chk("t5_pend",     bus.oPENDING, 0);
    tick();
    chk("t5_err_hold", bus.oERR_UNDERFLOW, 1);
    bus.iREMOVE = 1;
    tick();
    bus.iREMOVE = 0;
    #1;
    chk("t5_err_clr",  bus.oERR_UNDERFLOW, 0);
    chk("t5_pend_clr", bus.oPENDING, 0);

    // flush with 2 outstanding
    bus.iCH0_REQ = 1; bus.iCH0_ADDR = 32'hC0;
    tick(); tick();
    #1;
    chk("t6_pend2", bus.oPENDING, 2);
    bus.iREMOVE = 1;
    #1;
    chk("t6_rm_req",   bus.oMEM_REQ, 0);
    chk("t6_rm_lock0", bus.oCH0_LOCK, 1);
    tick();
    bus.iREMOVE = 0;
    #1;
    chk("t6_pend0",  bus.oPENDING, 0);
    chk("t6_lock0",  bus.oCH0_LOCK, 0);
    tick();
    bus.iCH0_REQ = 0;
    #1;
    chk("t6_pend1", bus.oPENDING, 1);
    bus.iMEM_VALID = 1; bus.iMEM_DATA = 32'h12345678;
    #1;
    chk("t6_ch0_valid", bus.oCH0_VALID, 1);
    chk("t6_ch1_valid", bus.oCH1_VALID, 0);
    chk("t6_ch0_data",  bus.oCH0_DATA, 32'h12345678);
    tick();
    bus.iMEM_VALID = 0;
    #1;
    chk("t6_pend_end", bus.oPENDING, 0);
    chk("t6_err",      bus.oERR_UNDERFLOW, 0);

    // async reset mid-operation, then orphaned response
    bus.iCH1_REQ = 1;
    tick(); tick(); tick();
    bus.iCH1_REQ = 0;
    #1;
    chk("t7_pend3", bus.oPENDING, 3);
    #2 inRESET = 0;
    #1;
    chk("t7_rst_pend", bus.oPENDING, 0);
    chk("t7_rst_err",  bus.oERR_UNDERFLOW, 0);
    #3 inRESET = 1;
    tick();
    bus.iMEM_VALID = 1;
    #1;
    chk("t7_orphan_ch1", bus.oCH1_VALID, 0);
    tick();
    bus.iMEM_VALID = 0;
    #1;
    chk("t7_orphan_err", bus.oERR_UNDERFLOW, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
